// File: rtl/axi4_slave_mem_responder_pkg.sv
// Shared types for the AXI4 memory responder: response codes, burst kinds,
// engine state encodings and word geometry helpers.
package axi4_resp_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    localparam int BYTES_PER_WORD = 32;

    // Byte-address to word-index shift for a given data width.
    function automatic int word_shift(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi4_slave_mem_responder_if.sv
// AXI4 bus bundle between an initiator (master modport) and the memory responder (slave modport).
// valid/ready: a beat transfers on a rising edge where valid and ready are both high; once valid is raised its payload holds until that edge.
interface axi4_slave_mem_responder_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 64,
    parameter int ID_WIDTH   = 7
);
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;

    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;

    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arvalid;
    logic                    arready;

    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi4_slave_mem_responder_mem_array.sv
// Word memory for the responder: one byte-strobed synchronous write port and
// one combinational read port, so a same-edge read sees the pre-write contents.
module axi4_slave_mem_array #(
    parameter int DATA_WIDTH = 256,
    parameter int MEM_DEPTH  = 256,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                    axi_clk_in_clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Contents are deliberately never reset.
    always_ff @(posedge axi_clk_in_clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi4_slave_mem_responder.sv
// AXI4 responder backed by a word memory, with independent write and read engines (one transaction each).
// Define AXI_SLV_ERR_CHECK_EN to answer out-of-window addresses with DECERR and WRAP/reserved bursts with SLVERR.
module axi4_slave_mem_responder
    import axi4_resp_pkg::*;
#(
    parameter int                    DATA_WIDTH = 256,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    ID_WIDTH   = 7,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h0
) (
    input  logic                        axi_clk_in_clk,
    input  logic                        axi_reset_in_reset,
    axi4_slave_mem_responder_if.slave   s_axi,
    output wr_state_e                   dbg_wr_state,
    output rd_state_e                   dbg_rd_state
);

    localparam int BPW   = DATA_WIDTH / 8;
    localparam int SHIFT = word_shift(DATA_WIDTH);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    // Word index of a request: offset into the window, in words, modulo MEM_DEPTH.
    logic [ADDR_WIDTH-1:0] aw_off, ar_off;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    assign aw_off = s_axi.awaddr - BASE_ADDR;
    assign ar_off = s_axi.araddr - BASE_ADDR;
    assign aw_idx = aw_off[SHIFT +: IDX_W];
    assign ar_idx = ar_off[SHIFT +: IDX_W];

    resp_e aw_chk, ar_chk;
`ifdef AXI_SLV_ERR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] WIN_HI = WIN_LO + (ADDR_WIDTH+1)'(MEM_DEPTH * BPW);

    function automatic resp_e req_check(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [1:0]            burst);
        logic [ADDR_WIDTH:0] a;
        a = {1'b0, addr};
        if (a < WIN_LO || a >= WIN_HI) return RESP_DECERR;
        if (burst != BURST_FIXED && burst != BURST_INCR) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    assign aw_chk = req_check(s_axi.awaddr, s_axi.awburst);
    assign ar_chk = req_check(s_axi.araddr, s_axi.arburst);
`else
    assign aw_chk = RESP_OKAY;
    assign ar_chk = RESP_OKAY;
`endif

    // Beat size is always a full word; size and the high offset bits carry no information here.
    logic unused_bits;
    assign unused_bits = ^{s_axi.awsize, s_axi.arsize, aw_off, ar_off};

    // ---------------- write engine ----------------
    wr_state_e             wr_state;
    logic                  awready_q, wready_q, bvalid_q;
    logic [ID_WIDTH-1:0]   bid_q, w_id;
    resp_e                 bresp_q, w_err;
    logic [IDX_W-1:0]      w_idx;
    logic [7:0]            w_len, w_cnt;
    logic                  w_incr, w_lastbad;
    logic                  w_fire, w_final, mem_we;

    assign w_fire  = s_axi.wvalid && wready_q;
    assign w_final = (w_cnt == w_len);
    assign mem_we  = w_fire && (wr_state == W_DATA) && (w_err == RESP_OKAY)
                     && !axi_reset_in_reset;

    always_ff @(posedge axi_clk_in_clk) begin
        if (axi_reset_in_reset) begin
            wr_state  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            w_id      <= '0;
            w_err     <= RESP_OKAY;
            w_idx     <= '0;
            w_len     <= '0;
            w_cnt     <= '0;
            w_incr    <= 1'b0;
            w_lastbad <= 1'b0;
        end else begin
            case (wr_state)
                W_IDLE: begin
                    if (s_axi.awvalid && awready_q) begin
                        w_id      <= s_axi.awid;
                        w_idx     <= aw_idx;
                        w_len     <= s_axi.awlen;
                        w_cnt     <= '0;
                        w_incr    <= (s_axi.awburst == BURST_INCR);
                        w_err     <= aw_chk;
                        w_lastbad <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wr_state  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 8'd1;
                        if (w_incr) w_idx <= w_idx + 1'b1;
                        // The beat count ends the burst; wlast only grades the response.
                        if (w_final) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= w_id;
                            if (w_err != RESP_OKAY)
                                bresp_q <= w_err;
                            else if (w_lastbad || !s_axi.wlast)
                                bresp_q <= RESP_SLVERR;
                            else
                                bresp_q <= RESP_OKAY;
                            wr_state <= W_RESP;
                        end else if (s_axi.wlast) begin
                            w_lastbad <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_q && s_axi.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wr_state  <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // ---------------- read engine ----------------
    rd_state_e             rd_state;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [DATA_WIDTH-1:0] rdata_q, mem_rdata;
    resp_e                 rresp_q;
    logic [IDX_W-1:0]      r_idx, r_next, rd_raddr;
    logic [7:0]            r_len, r_cnt;
    logic                  r_incr;

    // Idle reads the requested word; mid-burst reads the following beat's word.
    assign r_next   = r_incr ? r_idx + 1'b1 : r_idx;
    assign rd_raddr = (rd_state == R_IDLE) ? ar_idx : r_next;

    always_ff @(posedge axi_clk_in_clk) begin
        if (axi_reset_in_reset) begin
            rd_state  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            r_idx     <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_incr    <= 1'b0;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (s_axi.arvalid && arready_q) begin
                        rid_q     <= s_axi.arid;
                        r_idx     <= ar_idx;
                        r_len     <= s_axi.arlen;
                        r_cnt     <= '0;
                        r_incr    <= (s_axi.arburst == BURST_INCR);
                        rresp_q   <= ar_chk;
                        rdata_q   <= (ar_chk == RESP_OKAY) ? mem_rdata : '0;
                        rlast_q   <= (s_axi.arlen == 8'd0);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        rd_state  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            rd_state  <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            r_idx   <= r_next;
                            rdata_q <= (rresp_q == RESP_OKAY) ? mem_rdata : '0;
                            rlast_q <= ((r_cnt + 8'd1) == r_len);
                        end
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

    axi4_slave_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .axi_clk_in_clk (axi_clk_in_clk),
        .we             (mem_we),
        .waddr          (w_idx),
        .wdata          (s_axi.wdata),
        .wstrb          (s_axi.wstrb),
        .raddr          (rd_raddr),
        .rdata          (mem_rdata)
    );

    assign s_axi.awready = awready_q;
    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

endmodule
